// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the MEM-stage bus master: state encoding, access-type
// decode, byte-enable and store-lane helpers.
package mem_bus_master_pkg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_WAIT = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_WAIT = S_WAIT,
    ST_DONE = S_DONE
  } state_t;

  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_HALF  = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_BYTEU = 3'b100;
  localparam logic [2:0] F3_HALFU = 3'b101;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Unsupported encodings fall through to a word access.
  function automatic size_t accessSize(input logic [2:0] f3);
    case (f3)
      F3_BYTE, F3_BYTEU: return SZ_BYTE;
      F3_HALF, F3_HALFU: return SZ_HALF;
      default:           return SZ_WORD;
    endcase
  endfunction

  function automatic logic isUnsigned(input logic [2:0] f3);
    return (f3 == F3_BYTEU) || (f3 == F3_HALFU);
  endfunction

  function automatic logic isMisaligned(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byteEnables(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return BE_BYTE << off;
      SZ_HALF: return BE_HALF << off;
      default: return BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] laneData(input size_t sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Load result formatting: picks the addressed lane of a bus word and
// sign- or zero-extends it according to the access type.
module mem_load_extend
  import mem_bus_master_pkg::*;
(
  input  logic [31:0] rawData,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byteOff,
  output logic [31:0] loadData
);

  logic [31:0] shifted;

  always_comb begin
    shifted  = rawData >> {byteOff, 3'b000};
    loadData = rawData;
    case (accessSize(funct3))
      SZ_BYTE: loadData = isUnsigned(funct3) ? {24'b0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: loadData = isUnsigned(funct3) ? {16'b0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
      default: loadData = rawData;
    endcase
  end

endmodule

// File: rtl/mem_bus_master.sv
// MEM-stage bus master: turns pipeline loads/stores into single bus
// transactions, stalling the pipeline until the responder acks or times out.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        MemStall,
  output logic [31:0] ReadDataM,
  output logic        MisalignedM,
  output logic        BusErrM,
  output logic        BusReq,
  output logic        BusWE,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusBE,
  input  logic        BusAck,
  input  logic [31:0] BusRData
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] waitCnt;
  logic [1:0]    offQ;
  logic [2:0]    funct3Q;
  logic [31:0]   rdataQ;

  logic  memReq;
  logic  misal;
  size_t reqSize;

  always_comb begin
    memReq      = MemReadM || MemWriteM;
    reqSize     = accessSize(Funct3M);
    misal       = isMisaligned(reqSize, ALUResultM[1:0]);
    MemStall    = !RESET && ((state == ST_WAIT) || (state == ST_IDLE && memReq && !misal));
    MisalignedM = !RESET && (state == ST_IDLE) && memReq && misal;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      waitCnt  <= '0;
      offQ     <= '0;
      funct3Q  <= '0;
      rdataQ   <= '0;
      BusErrM  <= 1'b0;
      BusReq   <= 1'b0;
      BusWE    <= 1'b0;
      BusAddr  <= '0;
      BusWData <= '0;
      BusBE    <= '0;
    end else begin
      BusErrM <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (memReq && !misal) begin
            offQ     <= ALUResultM[1:0];
            funct3Q  <= Funct3M;
            BusReq   <= 1'b1;
            BusWE    <= MemWriteM;
            BusAddr  <= {ALUResultM[31:2], 2'b00};
            BusBE    <= byteEnables(reqSize, ALUResultM[1:0]);
            BusWData <= laneData(reqSize, WriteDataM);
            waitCnt  <= '0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // An ack on the final permitted cycle still completes normally.
          if (BusAck) begin
            rdataQ  <= BusRData;
            BusReq  <= 1'b0;
            BusWE   <= 1'b0;
            waitCnt <= '0;
            state   <= ST_DONE;
          end else if (waitCnt == LAST_CNT) begin
            rdataQ  <= '0;
            BusErrM <= 1'b1;
            BusReq  <= 1'b0;
            BusWE   <= 1'b0;
            waitCnt <= '0;
            state   <= ST_DONE;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  mem_load_extend u_extend (
    .rawData (rdataQ),
    .funct3  (funct3Q),
    .byteOff (offQ),
    .loadData(ReadDataM)
  );

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: directed and randomized loads and
// stores against an arithmetic model of the bus protocol and data formatting.
module tb_mem_bus_master;

  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [2:0]  Funct3M = '0;
  logic [31:0] ALUResultM = '0, WriteDataM = '0;
  logic        MemStall, MisalignedM, BusErrM, BusReq, BusWE;
  logic [31:0] ReadDataM, BusAddr, BusWData;
  logic [3:0]  BusBE;
  logic        BusAck = 1'b0;
  logic [31:0] BusRData = '0;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mem_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .MemStall(MemStall), .ReadDataM(ReadDataM), .MisalignedM(MisalignedM),
    .BusErrM(BusErrM), .BusReq(BusReq), .BusWE(BusWE), .BusAddr(BusAddr),
    .BusWData(BusWData), .BusBE(BusBE), .BusAck(BusAck), .BusRData(BusRData)
  );

  function automatic int sizeBytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [3:0] expBE(input int sz, input logic [31:0] addr);
    int m;
    m = ((1 << sz) - 1) << (addr & 3);
    return m[3:0];
  endfunction

  function automatic logic [31:0] expWData(input int sz, input logic [31:0] d);
    if (sz == 1) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] rdata);
    int sz;
    logic [31:0] mask, v;
    sz = sizeBytes(f3);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
    v = (rdata >> (8 * (addr & 3))) & mask;
    if (!f3[2] && sz < 4 && ((v >> (8 * sz - 1)) & 1) == 1) v = v | ~mask;
    return v;
  endfunction

  // One pipeline access; ackAt = WAIT cycle (1-based) carrying BusAck, 0 = never.
  task automatic doAccess(input string name, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int ackAt);
    int sz;
    logic mis, timedOut;
    logic [31:0] ld;
    sz = sizeBytes(f3);
    mis = (addr % sz) != 0;
    ld = expLoad(f3, addr, rdata);
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr;
    WriteDataM = wdata; BusAck = 1'b0;
    #1;
    checks++; if (MemStall !== !mis) begin errors++; $display("FAIL %s issue MemStall: got %b want %b", name, MemStall, !mis); end
    checks++; if (MisalignedM !== mis) begin errors++; $display("FAIL %s MisalignedM: got %b want %b", name, MisalignedM, mis); end
    if (mis) begin
      @(posedge CLK); #1;
      MemReadM = 1'b0; MemWriteM = 1'b0; #1;
      checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL %s misaligned BusReq: got %b want 0", name, BusReq); end
      checks++; if (MisalignedM !== 1'b0) begin errors++; $display("FAIL %s misaligned pulse length: got %b want 0", name, MisalignedM); end
      return;
    end
    timedOut = 1'b1;
    for (int w = 1; w <= TMO; w++) begin
      @(posedge CLK); #1;
      checks++; if (BusReq !== 1'b1) begin errors++; $display("FAIL %s wait%0d BusReq: got %b want 1", name, w, BusReq); end
      checks++; if (MemStall !== 1'b1) begin errors++; $display("FAIL %s wait%0d MemStall: got %b want 1", name, w, MemStall); end
      checks++; if (BusWE !== wr) begin errors++; $display("FAIL %s wait%0d BusWE: got %b want %b", name, w, BusWE, wr); end
      checks++; if (BusAddr !== (addr & 32'hFFFF_FFFC)) begin errors++; $display("FAIL %s wait%0d BusAddr: got %h want %h", name, w, BusAddr, addr & 32'hFFFF_FFFC); end
      checks++; if (BusBE !== expBE(sz, addr)) begin errors++; $display("FAIL %s wait%0d BusBE: got %b want %b", name, w, BusBE, expBE(sz, addr)); end
      if (wr) begin
        checks++; if (BusWData !== expWData(sz, wdata)) begin errors++; $display("FAIL %s wait%0d BusWData: got %h want %h", name, w, BusWData, expWData(sz, wdata)); end
      end
      BusAck = (w == ackAt);
      BusRData = (w == ackAt) ? rdata : $urandom;
      if (w == ackAt) begin timedOut = 1'b0; break; end
    end
    @(posedge CLK); #1;
    BusAck = 1'($urandom_range(0, 1)); BusRData = $urandom; #1;
    checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL %s done BusReq: got %b want 0", name, BusReq); end
    checks++; if (MemStall !== 1'b0) begin errors++; $display("FAIL %s done MemStall: got %b want 0", name, MemStall); end
    checks++; if (BusErrM !== timedOut) begin errors++; $display("FAIL %s done BusErrM: got %b want %b", name, BusErrM, timedOut); end
    if (rd && !wr) begin
      checks++; if (ReadDataM !== (timedOut ? 32'h0 : ld)) begin errors++; $display("FAIL %s ReadDataM: got %h want %h", name, ReadDataM, timedOut ? 32'h0 : ld); end
    end
    @(posedge CLK); #1;
    checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL %s reissue BusReq: got %b want 0", name, BusReq); end
    checks++; if (BusErrM !== 1'b0) begin errors++; $display("FAIL %s BusErrM pulse length: got %b want 0", name, BusErrM); end
    MemReadM = 1'b0; MemWriteM = 1'b0; BusAck = 1'b0; #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    MemReadM = 1'b1; Funct3M = 3'd2; ALUResultM = $urandom; BusAck = 1'b1; BusRData = $urandom;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL reset BusReq: got %b want 0", BusReq); end
    checks++; if (BusWE !== 1'b0) begin errors++; $display("FAIL reset BusWE: got %b want 0", BusWE); end
    checks++; if (BusAddr !== 32'h0) begin errors++; $display("FAIL reset BusAddr: got %h want 0", BusAddr); end
    checks++; if (BusBE !== 4'h0) begin errors++; $display("FAIL reset BusBE: got %b want 0", BusBE); end
    checks++; if (BusWData !== 32'h0) begin errors++; $display("FAIL reset BusWData: got %h want 0", BusWData); end
    checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL reset ReadDataM: got %h want 0", ReadDataM); end
    checks++; if (BusErrM !== 1'b0) begin errors++; $display("FAIL reset BusErrM: got %b want 0", BusErrM); end
    checks++; if (MisalignedM !== 1'b0) begin errors++; $display("FAIL reset MisalignedM: got %b want 0", MisalignedM); end
    MemReadM = 1'b0; BusAck = 1'b0; RESET = 1'b0;
    @(posedge CLK); #1;
    checks++; if (MemStall !== 1'b0) begin errors++; $display("FAIL reset idle MemStall: got %b want 0", MemStall); end
  endtask

  task automatic test_directed();
    doAccess("lw_100", 1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    doAccess("lb_103", 1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 1);
    doAccess("lbu_103", 1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF0000, 2);
    doAccess("sh_202", 0, 1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 1);
    doAccess("lw_101", 1, 0, 3'd2, 32'h101, 32'h0, 32'h0, 1);
    doAccess("lhu_006", 1, 0, 3'd5, 32'h006, 32'h0, 32'h8001_7FFF, 3);
    doAccess("lh_006", 1, 0, 3'd5 & 3'd1, 32'h006, 32'h0, 32'h8001_7FFF, 1);
    doAccess("rd_and_wr", 1, 1, 3'd0, 32'h041, 32'h0000_00A5, 32'h0, 1);
    doAccess("f3_unsup", 1, 0, 3'd7, 32'h080, 32'h0, 32'hCAFE_F00D, 1);
  endtask

  task automatic test_timeout();
    doAccess("timeout", 1, 0, 3'd2, 32'h400, 32'h0, 32'h1234_5678, 0);
    doAccess("ack_last", 1, 0, 3'd2, 32'h404, 32'h0, 32'h8765_4321, TMO);
    doAccess("sw_timeout", 0, 1, 3'd2, 32'h408, 32'h5555_AAAA, 32'h0, 0);
  endtask

  task automatic test_ack_outside_wait();
    BusAck = 1'b1; BusRData = $urandom;
    repeat (3) begin
      @(posedge CLK); #1;
      checks++; if (BusReq !== 1'b0 || MemStall !== 1'b0 || BusErrM !== 1'b0) begin
        errors++; $display("FAIL idle_ack: got req=%b stall=%b err=%b want 0 0 0", BusReq, MemStall, BusErrM);
      end
    end
    BusAck = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    MemReadM = 1'b1; Funct3M = 3'd2; ALUResultM = 32'h300; BusAck = 1'b0;
    @(posedge CLK); #1;
    checks++; if (BusReq !== 1'b1) begin errors++; $display("FAIL rst_wait wait1 BusReq: got %b want 1", BusReq); end
    @(posedge CLK); #1;
    RESET = 1'b1; MemReadM = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0; #1;
    checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL rst_wait BusReq: got %b want 0", BusReq); end
    checks++; if (MemStall !== 1'b0) begin errors++; $display("FAIL rst_wait MemStall: got %b want 0", MemStall); end
    @(posedge CLK); #1;
    checks++; if (BusReq !== 1'b0 || BusErrM !== 1'b0) begin errors++; $display("FAIL rst_wait after: got req=%b err=%b want 0 0", BusReq, BusErrM); end
    checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL rst_wait ReadDataM: got %h want 0", ReadDataM); end
    doAccess("lw_after_rst", 1, 0, 3'd2, 32'h304, 32'h0, 32'h0BAD_F00D, 1);
  endtask

  task automatic test_random();
    logic [2:0] f3s [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 40; i++) begin
      logic rd, wr;
      logic [31:0] addr;
      int k;
      k = $urandom_range(0, 2);
      rd = (k != 1); wr = (k != 0);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'($urandom_range(0, 3)));
      doAccess("random", rd, wr, f3s[$urandom_range(0, 7)], addr, $urandom, $urandom,
               $urandom_range(0, TMO));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_ack_outside_wait();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
